uart_rx: RTL and testbench

//  16550A-style UART receive deserializer for the UART core. Samples serial line rx on a
//  16x-oversampling baud tick and assembles 5-8 data bits, LSB first, plus optional parity.
//  On the stop bit it outputs the data and pulses push (RX FIFO write strobe).
//  pe/fe/bi error flags are valid on the same cycle as push.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive deserializer: 16x-oversampled start/data/parity/stop framing
// with 5-8 data bits, optional parity, and pe/fe/bi flags valid alongside push.
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic [1:0] wls,
  output logic [7:0] rx_out,
  output logic       push,
  output logic       pe,
  output logic       fe,
  output logic       bi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bitidx_q, bitidx_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic [7:0] rx_out_q, rx_out_d;
  logic       push_q, push_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       bi_q, bi_d;

  logic       last_bit;
  logic       exp_par;

  // Index of the final data bit is N-1 = 4 + wls.
  assign last_bit = (bitidx_q == {1'b1, wls});
  // data_q is cleared on frame entry, so unused upper bits never disturb the XOR.
  assign exp_par  = sticky_parity ? ~eps : (eps ? ^data_q : ~^data_q);

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    data_d   = data_q;
    par_d    = par_q;
    rx_out_d = rx_out_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    bi_d     = bi_q;
    push_d   = 1'b0;

    if (baud_pulse) begin
      case (state_q)
        S_IDLE: begin
          if (!rx) begin
            state_d = S_START;
            cnt_d   = 4'd0;
          end
        end
        S_START: begin
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (!rx) begin
              state_d  = S_DATA;
              bitidx_d = 3'd0;
              data_d   = 8'h00;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            cnt_d            = 4'd0;
            data_d[bitidx_q] = rx;
            if (last_bit) begin
              state_d = pen ? S_PARITY : S_STOP;
            end else begin
              bitidx_d = bitidx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_PARITY: begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            par_d   = rx;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 4'd15) begin
            cnt_d    = 4'd0;
            state_d  = S_IDLE;
            push_d   = 1'b1;
            rx_out_d = data_q;
            fe_d     = ~rx;
            pe_d     = pen & (par_q != exp_par);
            bi_d     = (data_q == 8'h00) & ~rx & (~pen | ~par_q);
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // NOTE: the data shift register is reset along with control state so a
  // post-reset push can never expose stale bits from an aborted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      bitidx_q <= 3'd0;
      data_q   <= 8'h00;
      par_q    <= 1'b0;
      rx_out_q <= 8'h00;
      push_q   <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      bi_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      rx_out_q <= rx_out_d;
      push_q   <= push_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      bi_q     <= bi_d;
    end
  end

  assign rx_out = rx_out_q;
  assign push   = push_q;
  assign pe     = pe_q;
  assign fe     = fe_q;
  assign bi     = bi_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16-tick bits, tick every 6 clks; each scenario task
// drives frames and compares the held outputs against hand-computed values.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse = 1'b0;
  logic       rx;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic [1:0] wls;
  logic [7:0] rx_out;
  logic       push;
  logic       pe;
  logic       fe;
  logic       bi;

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt = 0;
  int div_cnt = 0;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse   (baud_pulse),
    .rx           (rx),
    .pen          (pen),
    .eps          (eps),
    .sticky_parity(sticky_parity),
    .wls          (wls),
    .rx_out       (rx_out),
    .push         (push),
    .pe           (pe),
    .fe           (fe),
    .bi           (bi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div_cnt    <= (div_cnt == 5) ? 0 : div_cnt + 1;
    baud_pulse <= (div_cnt == 5);
  end

  // A push held for more than one clock bumps this more than once per frame.
  always @(negedge clk) if (push === 1'b1) push_cnt++;

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_pulse !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx = 1'b1;
    wait_ticks(20);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1;
    pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; wls = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if ({rx_out, push, pe, fe, bi} !== 12'h000) begin n_err++;
      $display("FAIL reset_outputs got rx_out=%h push=%b pe=%b fe=%b bi=%b exp all 0", rx_out, push, pe, fe, bi); end
    @(negedge clk); rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_parity_good;
    int p0;
    wls = 2'b11; pen = 1'b1; eps = 1'b0; sticky_parity = 1'b0;
    p0 = push_cnt;
    send_frame(8'h45, 8, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t1_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h45) begin n_err++; $display("FAIL t1_data got %h exp 45", rx_out); end
    n_cmp++; if ({pe, fe, bi} !== 3'b000) begin n_err++; $display("FAIL t1_flags got pe/fe/bi=%b%b%b exp 000", pe, fe, bi); end
  endtask

  task automatic test_parity_error;
    int p0;
    p0 = push_cnt;
    send_frame(8'h45, 8, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t2_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h45) begin n_err++; $display("FAIL t2_data got %h exp 45", rx_out); end
    n_cmp++; if ({pe, fe, bi} !== 3'b100) begin n_err++; $display("FAIL t2_flags got pe/fe/bi=%b%b%b exp 100", pe, fe, bi); end
  endtask

  task automatic test_framing_error;
    int p0;
    p0 = push_cnt;
    send_frame(8'h45, 8, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t3_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h45) begin n_err++; $display("FAIL t3_data got %h exp 45", rx_out); end
    n_cmp++; if ({pe, fe, bi} !== 3'b010) begin n_err++; $display("FAIL t3_flags got pe/fe/bi=%b%b%b exp 010", pe, fe, bi); end
  endtask

  task automatic test_break;
    int p0;
    p0 = push_cnt;
    // All-zero odd-parity frame expects parity 1, so a low line also flags pe.
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t4_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h00) begin n_err++; $display("FAIL t4_data got %h exp 00", rx_out); end
    n_cmp++; if ({pe, fe, bi} !== 3'b111) begin n_err++; $display("FAIL t4_flags got pe/fe/bi=%b%b%b exp 111", pe, fe, bi); end
  endtask

  task automatic test_short_word_glitch;
    int p0;
    wls = 2'b00; pen = 1'b0;
    p0 = push_cnt;
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t5_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h15) begin n_err++; $display("FAIL t5_data got %h exp 15", rx_out); end
    n_cmp++; if ({pe, fe, bi} !== 3'b000) begin n_err++; $display("FAIL t5_flags got pe/fe/bi=%b%b%b exp 000", pe, fe, bi); end
    p0 = push_cnt;
    rx = 1'b0; wait_ticks(3);
    rx = 1'b1; wait_ticks(40);
    n_cmp++; if (push_cnt - p0 !== 0) begin n_err++; $display("FAIL t5_glitch_push got %0d exp 0", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h15) begin n_err++; $display("FAIL t5_glitch_hold got %h exp 15", rx_out); end
    wls = 2'b01;
    p0 = push_cnt;
    send_frame(8'h2A, 6, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t5_after_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h2A) begin n_err++; $display("FAIL t5_after_data got %h exp 2a", rx_out); end
  endtask

  task automatic test_sticky;
    int p0;
    wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b1;
    // 0x07 has odd weight: plain even parity would want 1, stick parity wants 0.
    p0 = push_cnt;
    send_frame(8'h07, 8, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t6_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h07) begin n_err++; $display("FAIL t6_data got %h exp 07", rx_out); end
    n_cmp++; if ({pe, fe, bi} !== 3'b000) begin n_err++; $display("FAIL t6_flags got pe/fe/bi=%b%b%b exp 000", pe, fe, bi); end
    send_frame(8'h07, 8, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (pe !== 1'b1) begin n_err++; $display("FAIL t6_sticky_pe got %b exp 1", pe); end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    p0 = push_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if ({rx_out, push, pe, fe, bi} !== 12'h000) begin n_err++;
      $display("FAIL t7_rst_outputs got rx_out=%h push=%b pe=%b fe=%b bi=%b exp all 0", rx_out, push, pe, fe, bi); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wait_ticks(40);
    n_cmp++; if (push_cnt - p0 !== 0) begin n_err++; $display("FAIL t7_abort_push got %0d exp 0", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h00) begin n_err++; $display("FAIL t7_abort_data got %h exp 00", rx_out); end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (push_cnt - p0 !== 1) begin n_err++; $display("FAIL t7_resume_push got %0d exp 1", push_cnt - p0); end
    n_cmp++; if (rx_out !== 8'h3C) begin n_err++; $display("FAIL t7_resume_data got %h exp 3c", rx_out); end
  endtask

  initial begin
    test_reset();
    test_parity_good();
    test_parity_error();
    test_framing_error();
    test_break();
    test_short_word_glitch();
    test_sticky();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
